// File: rtl/rv32i_reg_file_pkg.sv
// Shared RV32I register-file constants and types, also used by the pipeline
// forwarding and hazard logic.
package rv32i_reg_file_pkg;

  localparam int RV_XLEN    = 32;
  localparam int RV_NREGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [RV_XLEN-1:0]    xword_t;

  // True when the address selects the hardwired-zero register x0.
  function automatic logic is_x0(input reg_addr_t addr);
    return (addr == {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 zeroing, write-back bypass compare and the
// register array mux.
module rf_read_port
  import rv32i_reg_file_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int NREGS = RV_NREGS,
  parameter int AW    = REG_ADDR_W
) (
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [AW-1:0]   addr,
  input  logic            byp_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] data
);

  // Read select: x0 wins over everything, then the in-flight write, then the array.
  always_comb begin
    data = {XLEN{1'b0}};
    if (addr == {AW{1'b0}}) begin
      data = {XLEN{1'b0}};
    end else if (byp_en && (wr_addr == addr)) begin
      data = wr_data;
    end else begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/rv32i_reg_file.sv
// RV32I integer register file: x1..x31 in flops, x0 hardwired to zero,
// two asynchronous read ports and one synchronous write port.
module rv32i_reg_file
  import rv32i_reg_file_pkg::*;
#(
  parameter int XLEN      = RV_XLEN,
  parameter int NREGS     = RV_NREGS,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [XLEN-1:0]          rd_data,
  input  logic                     we,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_r      [1:NREGS-1];
  logic [XLEN-1:0] regs_view_s [NREGS];
  logic            byp_en_s;

  // Register array update: clear-all has priority over the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (we && (rd == AW'(i))) begin
          regs_r[i] <= rd_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Present the array with a constant-zero x0 slot to the read muxes.
  always_comb begin
    regs_view_s[0] = {XLEN{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      regs_view_s[i] = regs_r[i];
    end
  end

  // A reset edge discards the write, so it must not be forwarded either.
  assign byp_en_s = WB_BYPASS && !reset && we;

  rf_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_port1 (
    .regs    (regs_view_s),
    .addr    (rs1),
    .byp_en  (byp_en_s),
    .wr_addr (rd),
    .wr_data (rd_data),
    .data    (rs1_data)
  );

  rf_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_port2 (
    .regs    (regs_view_s),
    .addr    (rs2),
    .byp_en  (byp_en_s),
    .wr_addr (rd),
    .wr_data (rd_data),
    .data    (rs2_data)
  );

endmodule

// File: tb/tb_rv32i_reg_file.sv
// Self-checking bench for rv32i_reg_file: reference array model feeding a
// queue of expected read-port values.
module tb_rv32i_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rd_data;
  logic        we;
  logic [31:0] rs1_data, rs2_data;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] model [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  rv32i_reg_file #(.XLEN(32), .NREGS(32), .WB_BYPASS(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .rd_data  (rd_data),
    .we       (we),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read: x0 is zero, an active non-reset write is forwarded.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!reset && we && (rd == a)) return rd_data;
    return model[a];
  endfunction

  task automatic push_read(input logic [4:0] a, input logic [4:0] b, input string nm);
    exp_t x;
    rs1 = a;
    rs2 = b;
    x.d1 = model_read(a);
    x.d2 = model_read(b);
    x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; rd = a; rd_data = d;
    @(posedge clk);
    #1;
    if (!reset && a != 5'd0) model[a] = d;
    we = 1'b0;
  endtask

  task automatic do_reset_edge();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    push_read(5'd0, 5'd0, "pre_reset_x0");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
    do_reset_edge();
    push_read(5'd0, 5'd1, "reset_x0_x1");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
    push_read(5'd2, 5'd31, "reset_x2_x31");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
  endtask

  task automatic test_basic_write();
    do_write(5'd1, 32'hA5A5A5A5);
    do_write(5'd2, 32'h12345678);
    push_read(5'd1, 5'd2, "basic_x1_x2");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
  endtask

  task automatic test_x0_protect();
    @(negedge clk);
    we = 1'b1; rd = 5'd0; rd_data = 32'hFFFFFFFF;
    push_read(5'd0, 5'd0, "x0_during_write");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    push_read(5'd0, 5'd1, "x0_after_write");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
  endtask

  task automatic test_comb_read();
    push_read(5'd2, 5'd1, "comb_x2_x1");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
    push_read(5'd2, 5'd2, "comb_same_reg");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; rd = 5'd5; rd_data = 32'hDEADBEEF;
    push_read(5'd5, 5'd1, "bypass_x5");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
    @(posedge clk);
    #1;
    model[5] = 32'hDEADBEEF;
    we = 1'b0;
    push_read(5'd1, 5'd5, "stored_x5");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1; we = 1'b1; rd = 5'd5; rd_data = 32'hCAFEF00D;
    push_read(5'd5, 5'd5, "reset_suppresses_bypass");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    push_read(5'd5, 5'd1, "reset_beats_write");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
  endtask

  task automatic test_reset_again();
    do_write(5'd1, 32'h0BADF00D);
    do_write(5'd2, 32'h13579BDF);
    do_reset_edge();
    push_read(5'd1, 5'd2, "reset_again_x1_x2");
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
      n_bad++;
      $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
    end
  endtask

  task automatic test_all_regs();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      push_read(5'(i), 5'(31 - i), $sformatf("all_regs_%0d", i));
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
        n_bad++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a;
    logic [31:0] d;
    for (int n = 0; n < 40; n++) begin
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      @(negedge clk);
      we = 1'b1; rd = a; rd_data = d;
      push_read(((n % 3) == 0) ? a : 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                $sformatf("b2b_%0d", n));
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
        n_bad++;
        $display("FAIL %s: got %h/%h expected %h/%h", e.name, rs1_data, rs2_data, e.d1, e.d2);
      end
      @(posedge clk);
      #1;
      if (a != 5'd0) model[a] = d;
    end
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; rd = 5'd0; rd_data = 32'h0; rs1 = 5'd0; rs2 = 5'd0;
    test_reset();
    test_basic_write();
    test_x0_protect();
    test_comb_read();
    test_bypass();
    test_reset_priority();
    test_reset_again();
    test_all_regs();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
